// File: rtl/stage_admit_ctrl_pkg.sv
// Shared definitions for the stage admission controller.
// Holds the admission FSM state encoding and the default PHV and VLAN widths
// that the match-action stage modules already use.
package stage_admit_ctrl_pkg;

  localparam int unsigned PHV_LEN_DEF        = 32'd2304;  // 32*64 + 256
  localparam int unsigned C_VLANID_WIDTH_DEF = 32'd12;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } admit_state_e;

endpackage

// File: rtl/stage_admit_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk/rst (synchronous, active-high), req[1:0] requests,
// advance (a grant is actually consumed this cycle), grant[1:0] one-hot grant.
// The pointer names the side that wins a tie; it only moves when advance is
// high, and then points away from the side just served.
module rr_arb2
  import stage_admit_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and next pointer value.
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    // Serving side 0 makes side 1 the next tie winner and vice versa,
    // which is exactly grant[0].
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stage_admit_ctrl.sv
// Admission controller in front of the first match-action stage.
// Merges PHV+VLAN pairs from requester 0 (parser) and requester 1
// (recirculation) with packet-atomic round-robin, limits PHVs in flight via a
// credit counter and offers a flush/drain handshake for table updates.
// Ports:
//   axis_clk, areset (sync, active-high)
//   sN_phv_in/_valid, sN_vlan_in/_valid : requester N pair; sN_ready pulses on load
//   phv_out/_valid, vlan_out/vlan_valid_out : registered pair to the stage
//   stage_ready_in, vlan_ready_in : stage acceptance (both required)
//   credit_return : one pulse per PHV leaving the last stage
//   flush_req / flush_done : drain request and pipeline-empty indication
//   inflight_cnt, last_src, credit_err : status
module stage_admit_ctrl
  import stage_admit_ctrl_pkg::*;
#(
  parameter int PHV_LEN        = PHV_LEN_DEF,
  parameter int C_VLANID_WIDTH = C_VLANID_WIDTH_DEF,
  parameter int MAX_INFLIGHT   = 8,
  parameter int CNT_W          = 4
) (
  input  logic                      axis_clk,
  input  logic                      areset,
  input  logic [PHV_LEN-1:0]        s0_phv_in,
  input  logic                      s0_phv_valid,
  input  logic [C_VLANID_WIDTH-1:0] s0_vlan_in,
  input  logic                      s0_vlan_valid,
  output logic                      s0_ready,
  input  logic [PHV_LEN-1:0]        s1_phv_in,
  input  logic                      s1_phv_valid,
  input  logic [C_VLANID_WIDTH-1:0] s1_vlan_in,
  input  logic                      s1_vlan_valid,
  output logic                      s1_ready,
  output logic [PHV_LEN-1:0]        phv_out,
  output logic                      phv_out_valid,
  output logic [C_VLANID_WIDTH-1:0] vlan_out,
  output logic                      vlan_valid_out,
  input  logic                      stage_ready_in,
  input  logic                      vlan_ready_in,
  input  logic                      credit_return,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [CNT_W-1:0]          inflight_cnt,
  output logic                      last_src,
  output logic                      credit_err
);

  admit_state_e              state_q, state_d;
  logic                      out_v_q, out_v_d;
  logic [PHV_LEN-1:0]        phv_q, phv_d;
  logic [C_VLANID_WIDTH-1:0] vlan_q, vlan_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      last_src_q, last_src_d;
  logic                      flush_done_q, flush_done_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       accept;
  logic       load_en;
  logic       cnt_dec;

  rr_arb2 u_arb (
    .clk     (axis_clk),
    .rst     (areset),
    .req     (req),
    .advance (load_en),
    .grant   (grant)
  );

  // Request decode, acceptance and the load decision.
  always_comb begin
    // A pair is only a request when both halves are valid.
    req     = {s1_phv_valid & s1_vlan_valid, s0_phv_valid & s0_vlan_valid};
    accept  = out_v_q & stage_ready_in & vlan_ready_in;
    // Compare against the registered count: a credit arriving while full
    // only opens the window on the following cycle.
    load_en = !areset && (state_q == ST_RUN) && (!out_v_q || accept) &&
              (cnt_q < CNT_W'(MAX_INFLIGHT)) && (req != 2'b00);
  end

  // Output register, last source and credit counter next values.
  always_comb begin
    phv_d      = phv_q;
    vlan_d     = vlan_q;
    out_v_d    = out_v_q;
    last_src_d = last_src_q;
    if (load_en) begin
      out_v_d    = 1'b1;
      last_src_d = grant[1];
      if (grant[1]) begin
        phv_d  = s1_phv_in;
        vlan_d = s1_vlan_in;
      end else begin
        phv_d  = s0_phv_in;
        vlan_d = s0_vlan_in;
      end
    end else if (accept) begin
      out_v_d = 1'b0;
    end else begin
      out_v_d = out_v_q;
    end

    // A credit at zero cannot underflow; it is flagged instead.
    cnt_dec = credit_return && (cnt_q != {CNT_W{1'b0}});
    err_d   = err_q | (credit_return && (cnt_q == {CNT_W{1'b0}}));
    case ({load_en, cnt_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Run / drain / drained sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush_req) state_d = ST_DRAIN;
        else           state_d = ST_RUN;
      end
      ST_DRAIN: begin
        // Withdrawing the request aborts the drain straight back to RUN.
        if (!flush_req)                                      state_d = ST_RUN;
        else if ((cnt_q == {CNT_W{1'b0}}) && !out_v_q)       state_d = ST_DRAINED;
        else                                                 state_d = ST_DRAIN;
      end
      ST_DRAINED: begin
        if (!flush_req) state_d = ST_RUN;
        else            state_d = ST_DRAINED;
      end
      default: state_d = ST_RUN;
    endcase
    flush_done_d = (state_d == ST_DRAINED);
  end

  // State and output registers; a pair held at reset is dropped.
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state_q      <= ST_RUN;
      out_v_q      <= 1'b0;
      phv_q        <= {PHV_LEN{1'b0}};
      vlan_q       <= {C_VLANID_WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      err_q        <= 1'b0;
      last_src_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_v_q      <= out_v_d;
      phv_q        <= phv_d;
      vlan_q       <= vlan_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      last_src_q   <= last_src_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign s0_ready       = load_en & grant[0];
  assign s1_ready       = load_en & grant[1];
  assign phv_out        = phv_q;
  assign vlan_out       = vlan_q;
  assign phv_out_valid  = out_v_q;
  assign vlan_valid_out = out_v_q;
  assign inflight_cnt   = cnt_q;
  assign last_src       = last_src_q;
  assign credit_err     = err_q;
  assign flush_done     = flush_done_q;

endmodule

// File: tb/tb_stage_admit_ctrl.sv
// Bench for stage_admit_ctrl: a transaction-level reference model predicts
// which pair is admitted each cycle and pushes it into a scoreboard queue;
// a separate monitor pops and compares whenever the stage accepts a pair.
module tb_stage_admit_ctrl;

  localparam int PL   = 2304;
  localparam int VW   = 12;
  localparam int MAXI = 8;
  localparam int CW   = 4;

  logic          axis_clk = 1'b0;
  logic          areset;
  logic [PL-1:0] s0_phv_in, s1_phv_in, phv_out;
  logic [VW-1:0] s0_vlan_in, s1_vlan_in, vlan_out;
  logic          s0_phv_valid, s0_vlan_valid, s0_ready;
  logic          s1_phv_valid, s1_vlan_valid, s1_ready;
  logic          phv_out_valid, vlan_valid_out;
  logic          stage_ready_in, vlan_ready_in, credit_return, flush_req;
  logic          flush_done, last_src, credit_err;
  logic [CW-1:0] inflight_cnt;

  stage_admit_ctrl #(.PHV_LEN(PL), .C_VLANID_WIDTH(VW), .MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .axis_clk(axis_clk), .areset(areset),
    .s0_phv_in(s0_phv_in), .s0_phv_valid(s0_phv_valid), .s0_vlan_in(s0_vlan_in),
    .s0_vlan_valid(s0_vlan_valid), .s0_ready(s0_ready),
    .s1_phv_in(s1_phv_in), .s1_phv_valid(s1_phv_valid), .s1_vlan_in(s1_vlan_in),
    .s1_vlan_valid(s1_vlan_valid), .s1_ready(s1_ready),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .vlan_out(vlan_out),
    .vlan_valid_out(vlan_valid_out), .stage_ready_in(stage_ready_in),
    .vlan_ready_in(vlan_ready_in), .credit_return(credit_return),
    .flush_req(flush_req), .flush_done(flush_done), .inflight_cnt(inflight_cnt),
    .last_src(last_src), .credit_err(credit_err)
  );

  always #5 axis_clk = ~axis_clk;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [PL-1:0] phv;
    logic [VW-1:0] vlan;
  } pair_t;
  pair_t sb[$];

  // Reference model: mode 0 = admitting, 1 = draining, 2 = drained.
  int m_cnt;
  bit m_ptr, m_outv, m_last, m_err;
  int m_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PL-1:0] rand_phv();
    logic [PL-1:0] r;
    for (int i = 0; i < PL / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_outv = 0; m_last = 0; m_err = 0; m_mode = 0;
    sb.delete();
  endtask

  task automatic check_regs();
    chk("inflight_cnt", inflight_cnt, m_cnt);
    chk("flush_done", flush_done, (m_mode == 2) ? 1 : 0);
    chk("credit_err", credit_err, m_err);
    chk("out_valid", phv_out_valid, m_outv);
    chk("valid_pair", vlan_valid_out, phv_out_valid);
    chk("last_src", last_src, m_last);
  endtask

  // One clock: predict this cycle's admission, check readies, advance model.
  task automatic step();
    bit r0, r1, acc, ld, src, crd;
    int nmode;
    #1;
    r0  = s0_phv_valid && s0_vlan_valid;
    r1  = s1_phv_valid && s1_vlan_valid;
    acc = m_outv && stage_ready_in && vlan_ready_in;
    ld  = (m_mode == 0) && (!m_outv || acc) && (m_cnt < MAXI) && (r0 || r1);
    src = (r0 && r1) ? m_ptr : r1;
    chk("s0_ready", s0_ready, ld && !src);
    chk("s1_ready", s1_ready, ld && src);
    if (ld) sb.push_back('{src ? s1_phv_in : s0_phv_in, src ? s1_vlan_in : s0_vlan_in});
    nmode = m_mode;
    case (m_mode)
      0:       if (flush_req) nmode = 1;
      1:       if (!flush_req) nmode = 0; else if (m_cnt == 0 && !m_outv) nmode = 2;
      2:       if (!flush_req) nmode = 0;
      default: nmode = 0;
    endcase
    crd = credit_return;
    if (crd && m_cnt == 0) m_err = 1;
    m_cnt = m_cnt + (ld ? 1 : 0) - ((crd && m_cnt > 0) ? 1 : 0);
    if (ld) begin
      m_outv = 1; m_ptr = !src; m_last = src;
    end else if (acc) begin
      m_outv = 0;
    end
    m_mode = nmode;
    @(posedge axis_clk);
    @(negedge axis_clk);
    check_regs();
  endtask

  task automatic new_data();
    s0_phv_in = rand_phv(); s1_phv_in = rand_phv();
    s0_vlan_in = VW'($urandom); s1_vlan_in = VW'($urandom);
  endtask

  task automatic set_valids(input bit v0, input bit v1);
    s0_phv_valid = v0; s0_vlan_valid = v0;
    s1_phv_valid = v1; s1_vlan_valid = v1;
  endtask

  // Reset while valids may be high: no grant in the reset cycle, all clear after.
  task automatic do_reset();
    areset = 1'b1; stage_ready_in = 1'b0; vlan_ready_in = 1'b0;
    credit_return = 1'b0; flush_req = 1'b0;
    #1;
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    @(posedge axis_clk);
    model_reset();
    @(negedge axis_clk);
    chk("rst_phv_zero", (phv_out == '0) ? 1 : 0, 1);
    chk("rst_vlan_zero", vlan_out, 0);
    check_regs();
    areset = 1'b0;
  endtask

  // Monitor: compares every accepted pair against the scoreboard head.
  always @(negedge axis_clk) begin
    pair_t e;
    #2;
    if (!areset && phv_out_valid && stage_ready_in && vlan_ready_in) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL accept_unexpected: got a pair, expected none at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("phv_out_lo", phv_out[63:0], e.phv[63:0]);
        chk("phv_out_hi", phv_out[PL-1 -: 64], e.phv[PL-1 -: 64]);
        checks++;
        if (phv_out !== e.phv) begin
          errs++;
          $display("FAIL phv_out_full: got a different PHV, expected the admitted one at %0t", $time);
        end
        chk("vlan_out", vlan_out, e.vlan);
      end
    end
  end

  initial begin
    bit got;
    set_valids(0, 0); new_data();
    stage_ready_in = 0; vlan_ready_in = 0; credit_return = 0; flush_req = 0;
    areset = 1;
    @(negedge axis_clk);
    do_reset();

    // Both requesters continuously, full acceptance, credits flowing.
    set_valids(1, 1); stage_ready_in = 1; vlan_ready_in = 1;
    for (int i = 0; i < 16; i++) begin
      new_data(); credit_return = (m_cnt > 0); step();
    end

    // Lone valid halves are not requests.
    set_valids(0, 0); s0_phv_valid = 1;
    for (int i = 0; i < 4; i++) begin credit_return = (m_cnt > 0); step(); end
    s0_vlan_valid = 1; new_data(); credit_return = (m_cnt > 0); step();
    set_valids(0, 0);
    for (int i = 0; i < 3; i++) begin credit_return = (m_cnt > 0); step(); end

    // Stage stalls for 5 cycles while requests wait.
    set_valids(1, 1); new_data(); step();
    stage_ready_in = 0;
    for (int i = 0; i < 5; i++) begin new_data(); credit_return = (m_cnt > 0); step(); end
    stage_ready_in = 1;
    for (int i = 0; i < 3; i++) begin new_data(); credit_return = (m_cnt > 0); step(); end

    // Credit limit: drain, then offer pairs with no credits returning.
    set_valids(0, 0);
    for (int i = 0; i < 12 && m_cnt > 0; i++) begin credit_return = 1; step(); end
    credit_return = 0;
    set_valids(1, 1);
    for (int i = 0; i < 10; i++) begin new_data(); step(); end
    chk("cnt_full", inflight_cnt, MAXI);
    credit_return = 1; new_data(); step();
    credit_return = 0;
    for (int i = 0; i < 2; i++) begin new_data(); step(); end
    chk("cnt_refill", inflight_cnt, MAXI);

    // Flush with five PHVs in flight.
    set_valids(0, 0); do_reset();
    stage_ready_in = 1; vlan_ready_in = 1; set_valids(1, 1);
    for (int i = 0; i < 5; i++) begin new_data(); step(); end
    set_valids(0, 0); flush_req = 1; step();
    set_valids(1, 1);
    for (int i = 0; i < 5; i++) begin credit_return = 1; step(); end
    credit_return = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin step(); got = flush_done; end
    chk("flush_done_reached", got, 1);
    flush_req = 0; step();
    new_data(); step();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      new_data();
      s0_phv_valid = $urandom_range(0, 3) != 0; s0_vlan_valid = $urandom_range(0, 3) != 0;
      s1_phv_valid = $urandom_range(0, 3) != 0; s1_vlan_valid = $urandom_range(0, 3) != 0;
      stage_ready_in = $urandom_range(0, 3) != 0; vlan_ready_in = $urandom_range(0, 3) != 0;
      credit_return = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 31) == 0) flush_req = !flush_req;
      step();
    end

    // Credit at zero is sticky; reset mid-hold clears everything.
    set_valids(0, 0); do_reset();
    credit_return = 1; step();
    credit_return = 0;
    for (int i = 0; i < 3; i++) step();
    chk("credit_err_sticky", credit_err, 1);
    set_valids(1, 1); new_data(); step();
    for (int i = 0; i < 2; i++) step();
    do_reset();
    set_valids(0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
